// File: rtl/pow_seq_ctrl.sv
// Signed integer power sequencer: Y = A^N via sign-magnitude LSB-first square-and-multiply.
// Optional build macro POW_OVF_SAT_EN saturates y on overflow instead of wrapping.
module pow_seq_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned EXP_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [EXP_W-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);

  typedef enum logic [2:0] {StIdle, StAbs, StLoop, StSign, StDone} state_e;

  localparam logic [WIDTH-1:0] One    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};

  state_e state_q, state_d;

  logic [WIDTH-1:0]   a_q, a_d;
  logic [EXP_W-1:0]   n_q, n_d;
  logic [EXP_W-1:0]   e_q, e_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   base_q, base_d;
  logic               neg_q, neg_d;
  logic               ovf_run_q, ovf_run_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               ovf_q, ovf_d;

  logic [2*WIDTH-1:0] acc_prod;
  logic [2*WIDTH-1:0] base_sq;
  logic [EXP_W-1:0]   e_shr;
  logic [WIDTH-1:0]   signed_acc;
  logic               sign_ovf;
  logic               ovf_final;

  assign acc_prod   = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, base_q};
  assign base_sq    = {{WIDTH{1'b0}}, base_q} * {{WIDTH{1'b0}}, base_q};
  assign e_shr      = e_q >> 1;
  assign signed_acc = neg_q ? (~acc_q + One) : acc_q;
  // A negative result may reach exactly -2^(WIDTH-1); a positive one may not.
  assign sign_ovf   = neg_q ? (acc_q > MinNeg) : (acc_q >= MinNeg);
  assign ovf_final  = ovf_run_q | sign_ovf;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StAbs;
      StAbs:   state_d = (n_q == '0) ? StSign : StLoop;
      StLoop:  if (e_shr == '0) state_d = StSign;
      StSign:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      StAbs, StLoop, StSign: busy = 1'b1;
      StDone:                done = 1'b1;
      default:               ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    a_d       = a_q;
    n_d       = n_q;
    e_d       = e_q;
    acc_d     = acc_q;
    base_d    = base_q;
    neg_d     = neg_q;
    ovf_run_d = ovf_run_q;
    y_d       = y_q;
    ovf_d     = ovf_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          a_d       = a;
          n_d       = n;
          neg_d     = a[WIDTH-1] & n[0];
          ovf_run_d = 1'b0;
        end
      end
      StAbs: begin
        base_d = a_q[WIDTH-1] ? (~a_q + One) : a_q;
        acc_d  = One;
        e_d    = n_q;
      end
      StLoop: begin
        if (e_q[0]) begin
          acc_d = acc_prod[WIDTH-1:0];
          if (|acc_prod[2*WIDTH-1:WIDTH]) ovf_run_d = 1'b1;
        end
        // A wrapped square only matters if a later multiply will consume it.
        if ((|base_sq[2*WIDTH-1:WIDTH]) && (|e_q[EXP_W-1:1])) ovf_run_d = 1'b1;
        base_d = base_sq[WIDTH-1:0];
        e_d    = e_shr;
      end
      StSign: begin
        ovf_d = ovf_final;
`ifdef POW_OVF_SAT_EN
        if (ovf_final) begin
          y_d = neg_q ? MinNeg : MaxPos;
        end else begin
          y_d = signed_acc;
        end
`else
        y_d = signed_acc;
`endif
      end
      default: ;
    endcase
  end

  // Datapath registers; y/ovf load on the SIGN->DONE edge so they are valid with done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q       <= '0;
      n_q       <= '0;
      e_q       <= '0;
      acc_q     <= '0;
      base_q    <= '0;
      neg_q     <= 1'b0;
      ovf_run_q <= 1'b0;
      y_q       <= '0;
      ovf_q     <= 1'b0;
    end else begin
      a_q       <= a_d;
      n_q       <= n_d;
      e_q       <= e_d;
      acc_q     <= acc_d;
      base_q    <= base_d;
      neg_q     <= neg_d;
      ovf_run_q <= ovf_run_d;
      y_q       <= y_d;
      ovf_q     <= ovf_d;
    end
  end

  assign y   = y_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_pow_seq_ctrl.sv
// Scoreboard bench for pow_seq_ctrl: directed operations push expected results,
// a done-triggered monitor pops and checks y, ovf, done timing and busy length.
module tb_pow_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [5:0]  n = '0;
  logic        busy;
  logic        done;
  logic [31:0] y;
  logic        ovf;

  int vectors = 0;
  int miscompares = 0;
  int unsigned cyc = 0;
  int unsigned busy_run = 0;

  typedef struct {
    logic [31:0] y;
    logic        ovf;
    int unsigned done_cyc;
    int unsigned busy_len;
    string       name;
  } exp_t;

  exp_t sb[$];

  pow_seq_ctrl #(
    .WIDTH (32),
    .EXP_W (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .n     (n),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: busy_run holds the length of the busy stretch that precedes each done.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_y"}, {32'd0, y}, {32'd0, e.y});
        chk({e.name, "_ovf"}, {63'd0, ovf}, {63'd0, e.ovf});
        chk({e.name, "_done_cyc"}, {32'd0, cyc}, {32'd0, e.done_cyc});
        chk({e.name, "_busy_len"}, {32'd0, busy_run}, {32'd0, e.busy_len});
        chk({e.name, "_busy_at_done"}, {63'd0, busy}, 64'd0);
      end
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
  end

  // k is the bit-length of n; done lands k+3 cycles after the cycle start is sampled.
  task automatic issue(input logic [31:0] ai, input logic [5:0] ni, input logic [31:0] ye,
                       input logic oe, input int unsigned k, input string nm);
    exp_t e;
    @(negedge clk);
    a = ai;
    n = ni;
    start = 1'b1;
    e.y = ye;
    e.ovf = oe;
    e.done_cyc = cyc + k + 3;
    e.busy_len = k + 2;
    e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk({nm, "_timeout"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    int unsigned c;
    logic [31:0] y_2_31;
    logic [31:0] y_m2p31_2;
    logic [31:0] y_3_21;
`ifdef POW_OVF_SAT_EN
    y_2_31    = 32'h7FFF_FFFF;
    y_m2p31_2 = 32'h7FFF_FFFF;
    y_3_21    = 32'h7FFF_FFFF;
`else
    y_2_31    = 32'h8000_0000;
    y_m2p31_2 = 32'h0000_0000;
    y_3_21    = 32'h6F7C_52B3;
`endif

    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_y", {32'd0, y}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'd3,          6'd4,  32'd81,          1'b0, 3, "p3_4");
    issue(32'hFFFF_FFFE,  6'd3,  32'hFFFF_FFF8,   1'b0, 2, "m2_3");
    issue(32'hFFFF_FFFE,  6'd31, 32'h8000_0000,   1'b0, 5, "m2_31");
    issue(32'd2,          6'd31, y_2_31,          1'b1, 5, "p2_31");
    issue(32'd5,          6'd0,  32'd1,           1'b0, 0, "p5_0");
    issue(32'd0,          6'd0,  32'd1,           1'b0, 0, "z_0");
    issue(32'd0,          6'd5,  32'd0,           1'b0, 3, "z_5");
    issue(32'hFFFF_FFFD,  6'd2,  32'd9,           1'b0, 2, "m3_2");
    issue(32'h8000_0000,  6'd1,  32'h8000_0000,   1'b0, 1, "min_1");
    issue(32'h8000_0000,  6'd2,  y_m2p31_2,       1'b1, 2, "min_2");
    issue(32'd3,          6'd21, y_3_21,          1'b1, 5, "p3_21");

    // Abort a long operation with a one-cycle reset while in LOOP.
    @(negedge clk);
    a = 32'd7;
    n = 6'd63;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_y", {32'd0, y}, 64'd0);
    chk("abort_ovf", {63'd0, ovf}, 64'd0);
    repeat (20) @(negedge clk);
    issue(32'hFFFF_FFFF, 6'd63, 32'hFFFF_FFFF, 1'b0, 6, "m1_63");

    // start held high: two back-to-back ops; operands change mid-op and must not be re-sampled.
    @(negedge clk);
    a = 32'd3;
    n = 6'd2;
    start = 1'b1;
    c = cyc;
    begin
      exp_t e0, e1;
      e0.y = 32'd9;   e0.ovf = 1'b0; e0.done_cyc = c + 5;  e0.busy_len = 4; e0.name = "b2b0";
      e1.y = 32'd125; e1.ovf = 1'b0; e1.done_cyc = c + 11; e1.busy_len = 4; e1.name = "b2b1";
      sb.push_back(e0);
      sb.push_back(e1);
    end
    @(negedge clk);
    a = 32'd5;
    n = 6'd3;
    for (int i = 0; i < 40 && cyc < c + 11; i++) @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("b2b_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
